// File: rtl/dft_bin_core.sv
// dft_bin_core: 16-point block DFT that pulls samples from a FIFO and emits bins k=1,2,3.
// Optional macro DFT_CORE_SAT_EN: saturate each output part instead of wrapping.
module dft_bin_core #(
  parameter int DATA_IN_W  = 12,
  parameter int DATA_OUT_W = 16,
  parameter int DFT_N      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_IN_W-1:0]  fifo_rdata,
  output logic                         fifo_rd,
  input  logic                         fifo_empty,
  output logic signed [DATA_OUT_W-1:0] data_re_out,
  output logic signed [DATA_OUT_W-1:0] data_im_out,
  output logic                         valid_out
);

  localparam int COEF_W = 12;
  localparam int PROD_W = DATA_IN_W + COEF_W;
  localparam int ACC_W  = 28;
  localparam int SH     = 10;
  localparam int SH_W   = ACC_W - SH;

  generate
    if (DFT_N != 16) begin : g_bad_n
      $error("dft_bin_core supports only DFT_N = 16");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_OUT   = 1'b1
  } state_t;

  state_t                      state_r, state_s;
  logic                        run_r;
  logic                        rd_s;
  logic                        rd_vld_r;
  logic [4:0]                  rd_cnt_r;
  logic [3:0]                  n_r;
  logic [1:0]                  bin_r;
  logic [3:0]                  ph_s      [3];
  logic signed [PROD_W-1:0]    prod_re_s [3];
  logic signed [PROD_W-1:0]    prod_im_s [3];
  logic signed [ACC_W-1:0]     acc_re_r  [3];
  logic signed [ACC_W-1:0]     acc_im_r  [3];
  logic signed [SH_W-1:0]      sel_re_s;
  logic signed [SH_W-1:0]      sel_im_s;
  logic signed [DATA_OUT_W-1:0] re_r, im_r;
  logic                        valid_r;

  // 2047*sin(2*pi*p/16), rounded; cosine is the same table offset by a quarter turn.
  function automatic logic signed [COEF_W-1:0] sin_lut(input logic [3:0] p);
    case (p)
      4'd0:    sin_lut = 12'sd0;
      4'd1:    sin_lut = 12'sd783;
      4'd2:    sin_lut = 12'sd1447;
      4'd3:    sin_lut = 12'sd1891;
      4'd4:    sin_lut = 12'sd2047;
      4'd5:    sin_lut = 12'sd1891;
      4'd6:    sin_lut = 12'sd1447;
      4'd7:    sin_lut = 12'sd783;
      4'd8:    sin_lut = 12'sd0;
      4'd9:    sin_lut = -12'sd783;
      4'd10:   sin_lut = -12'sd1447;
      4'd11:   sin_lut = -12'sd1891;
      4'd12:   sin_lut = -12'sd2047;
      4'd13:   sin_lut = -12'sd1891;
      4'd14:   sin_lut = -12'sd1447;
      4'd15:   sin_lut = -12'sd783;
      default: sin_lut = 12'sd0;
    endcase
  endfunction

  // Narrow the already-shifted accumulator to the output width.
  function automatic logic signed [DATA_OUT_W-1:0] narrow(input logic signed [SH_W-1:0] sh);
`ifdef DFT_CORE_SAT_EN
    logic signed [SH_W-1:0] sat_hi;
    logic signed [SH_W-1:0] sat_lo;
    sat_hi = SH_W'((2 ** (DATA_OUT_W - 1)) - 1);
    sat_lo = ~sat_hi;
    if (sh > sat_hi) begin
      narrow = sat_hi[DATA_OUT_W-1:0];
    end else if (sh < sat_lo) begin
      narrow = sat_lo[DATA_OUT_W-1:0];
    end else begin
      narrow = sh[DATA_OUT_W-1:0];
    end
`else
    narrow = sh[DATA_OUT_W-1:0];
`endif
  endfunction

  // Next state and FIFO read strobe; reads stop once all 16 samples are requested.
  always_comb begin
    state_s = state_r;
    rd_s    = 1'b0;
    case (state_r)
      ST_FETCH: begin
        rd_s = run_r && !fifo_empty && (rd_cnt_r != 5'd16);
        if (rd_vld_r && (n_r == 4'd15)) begin
          state_s = ST_OUT;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_OUT: begin
        if (bin_r == 2'd2) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_OUT;
        end
      end
      default: state_s = ST_FETCH;
    endcase
  end

  // Twiddle phase (k*n mod 16) and per-bin products for the sample on fifo_rdata.
  always_comb begin
    ph_s[0] = n_r;
    ph_s[1] = {n_r[2:0], 1'b0};
    ph_s[2] = n_r + {n_r[2:0], 1'b0};
    for (int k = 0; k < 3; k++) begin
      prod_re_s[k] = PROD_W'(fifo_rdata) * PROD_W'(sin_lut(ph_s[k] + 4'd4));
      prod_im_s[k] = PROD_W'(fifo_rdata) * PROD_W'(-sin_lut(ph_s[k]));
    end
  end

  // Select the bin being emitted, already scaled down by 2^10.
  always_comb begin
    sel_re_s = acc_re_r[0][ACC_W-1:SH];
    sel_im_s = acc_im_r[0][ACC_W-1:SH];
    case (bin_r)
      2'd0: begin
        sel_re_s = acc_re_r[0][ACC_W-1:SH];
        sel_im_s = acc_im_r[0][ACC_W-1:SH];
      end
      2'd1: begin
        sel_re_s = acc_re_r[1][ACC_W-1:SH];
        sel_im_s = acc_im_r[1][ACC_W-1:SH];
      end
      2'd2: begin
        sel_re_s = acc_re_r[2][ACC_W-1:SH];
        sel_im_s = acc_im_r[2][ACC_W-1:SH];
      end
      default: begin
        sel_re_s = acc_re_r[0][ACC_W-1:SH];
        sel_im_s = acc_im_r[0][ACC_W-1:SH];
      end
    endcase
  end

  // FSM state, read/sample counters and bin index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_FETCH;
      run_r    <= 1'b0;
      rd_vld_r <= 1'b0;
      rd_cnt_r <= 5'd0;
      n_r      <= 4'd0;
      bin_r    <= 2'd0;
    end else begin
      run_r    <= 1'b1;
      state_r  <= state_s;
      rd_vld_r <= rd_s;
      if (state_r == ST_OUT) begin
        if (bin_r == 2'd2) begin
          bin_r    <= 2'd0;
          rd_cnt_r <= 5'd0;
          n_r      <= 4'd0;
        end else begin
          bin_r <= bin_r + 2'd1;
        end
      end else begin
        if (rd_s) begin
          rd_cnt_r <= rd_cnt_r + 5'd1;
        end
        if (rd_vld_r) begin
          n_r <= n_r + 4'd1;
        end
      end
    end
  end

  // Accumulators: cleared after the last bin leaves, held while the FIFO stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        acc_re_r[k] <= '0;
        acc_im_r[k] <= '0;
      end
    end else if ((state_r == ST_OUT) && (bin_r == 2'd2)) begin
      for (int k = 0; k < 3; k++) begin
        acc_re_r[k] <= '0;
        acc_im_r[k] <= '0;
      end
    end else if (rd_vld_r) begin
      for (int k = 0; k < 3; k++) begin
        acc_re_r[k] <= acc_re_r[k] + ACC_W'(prod_re_s[k]);
        acc_im_r[k] <= acc_im_r[k] + ACC_W'(prod_im_s[k]);
      end
    end
  end

  // Output registers; data holds its last value when not valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      re_r    <= '0;
      im_r    <= '0;
      valid_r <= 1'b0;
    end else if (state_r == ST_OUT) begin
      re_r    <= narrow(sel_re_s);
      im_r    <= narrow(sel_im_s);
      valid_r <= 1'b1;
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign fifo_rd     = rd_s;
  assign data_re_out = re_r;
  assign data_im_out = im_r;
  assign valid_out   = valid_r;

endmodule

// File: tb/tb_dft_bin_core.sv
// Scoreboard bench for dft_bin_core: stimulus pushes expected bins, a monitor pops and compares.
// Honors DFT_CORE_SAT_EN in its reference model.
module tb_dft_bin_core;

  localparam int IN_W  = 12;
  localparam int OUT_W = 16;

  logic                    tb_clk     = 1'b0;
  logic                    rst        = 1'b0;
  logic signed [IN_W-1:0]  fifo_rdata = '0;
  logic                    fifo_rd;
  logic                    fifo_empty = 1'b1;
  logic signed [OUT_W-1:0] data_re_out;
  logic signed [OUT_W-1:0] data_im_out;
  logic                    valid_out;

  always #5 tb_clk = ~tb_clk;

  dft_bin_core #(.DATA_IN_W(IN_W), .DATA_OUT_W(OUT_W), .DFT_N(16)) dut (
    .clk(tb_clk), .rst(rst), .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd),
    .fifo_empty(fifo_empty), .data_re_out(data_re_out), .data_im_out(data_im_out),
    .valid_out(valid_out)
  );

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } bin_t;

  bin_t exp_q[$];
  int   fifo_q[$];
  int   c_tab[3][16];
  int   s_tab[3][16];
  int   blk[16];
  int   errors = 0, checks = 0;
  int   bins_seen = 0, rd_while_empty = 0, run_len = 0;
  int   cyc = 0, popped = 0, last_cyc = 0;
  bit   gaps_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
  endfunction

  function automatic logic signed [15:0] narrow(input longint acc);
    longint sh;
    sh = acc >>> 10;
`ifdef DFT_CORE_SAT_EN
    if (sh > 32767) sh = 32767;
    else if (sh < -32768) sh = -32768;
`endif
    return sh[15:0];
  endfunction

  // Golden DFT of blk[] using the rounded coefficient tables.
  task automatic push_model();
    longint ar, ai;
    bin_t b;
    for (int k = 0; k < 3; k++) begin
      ar = 0;
      ai = 0;
      for (int n = 0; n < 16; n++) begin
        ar += longint'(blk[n]) * longint'(c_tab[k][n]);
        ai += longint'(blk[n]) * longint'(s_tab[k][n]);
      end
      b.re = narrow(ar);
      b.im = narrow(ai);
      exp_q.push_back(b);
    end
  endtask

  task automatic push_const(input int re, input int im);
    bin_t b;
    b.re = 16'(re);
    b.im = 16'(im);
    repeat (3) exp_q.push_back(b);
  endtask

  task automatic feed(input int cnt);
    for (int n = 0; n < cnt; n++) begin
      while (fifo_q.size() >= 20) @(negedge tb_clk);
      @(negedge tb_clk);
      fifo_q.push_back(blk[n]);
    end
  endtask

  task automatic rand_block();
    int mode;
    mode = int'($urandom_range(0, 7));
    for (int n = 0; n < 16; n++) begin
      if (mode == 0) blk[n] = ($urandom_range(0, 1) == 1) ? 2047 : -2048;
      else blk[n] = int'($urandom_range(0, 4095)) - 2048;
    end
  endtask

  task automatic wait_drain();
    while (exp_q.size() != 0) @(negedge tb_clk);
    repeat (4) @(negedge tb_clk);
  endtask

  // FIFO model: one-cycle read latency, junk data when not reading.
  always @(posedge tb_clk) begin
    cyc++;
    if (!rst) begin
      popped = 0;
    end else if (fifo_rd) begin
      if (fifo_empty) rd_while_empty++;
      if (fifo_q.size() > 0) begin
        fifo_rdata <= 12'(fifo_q.pop_front());
        popped++;
        if (popped % 16 == 0) last_cyc = cyc;
      end
    end else begin
      fifo_rdata <= 12'($urandom);
    end
  end

  always @(negedge tb_clk) begin
    fifo_empty = !rst || (fifo_q.size() == 0) || (gaps_en && ($urandom_range(0, 3) == 0));
  end

  // Monitor: pop and compare each valid bin, check 3-cycle bursts and latency.
  always @(negedge tb_clk) begin
    bin_t e;
    if (rst) begin
      if (valid_out) begin
        if (run_len == 0) chk("latency", cyc - last_cyc, 2);
        run_len++;
        bins_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_bin", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("bin%0d_re", bins_seen), data_re_out, e.re);
          chk($sformatf("bin%0d_im", bins_seen), data_im_out, e.im);
        end
      end else if (run_len != 0) begin
        chk("valid_run_len", run_len, 3);
        run_len = 0;
      end
    end
  end

  initial begin
    #500000;
    chk("watchdog_timeout", 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    real pi;
    pi = 3.14159265358979;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 16; n++) begin
        c_tab[k][n] = rnd(2047.0 * $cos(2.0 * pi * (k + 1) * n / 16.0));
        s_tab[k][n] = -rnd(2047.0 * $sin(2.0 * pi * (k + 1) * n / 16.0));
      end
    end

    repeat (3) @(negedge tb_clk);
    chk("reset_valid", valid_out, 0);
    chk("reset_re", data_re_out, 0);
    chk("reset_im", data_im_out, 0);
    chk("reset_rd", fifo_rd, 0);
    rst = 1'b1;

    for (int n = 0; n < 16; n++) blk[n] = 0;
    push_const(0, 0);
    feed(16);
    for (int n = 0; n < 16; n++) blk[n] = 100;
    push_const(0, 0);
    feed(16);
    for (int n = 0; n < 16; n++) blk[n] = (n == 0) ? 1000 : 0;
    push_const(1999, 0);
    feed(16);
    for (int n = 0; n < 16; n++) blk[n] = rnd(1000.0 * $cos(2.0 * pi * n / 16.0));
    push_model();
    feed(16);
    for (int n = 0; n < 16; n++) blk[n] = (c_tab[0][n] >= 0) ? 2047 : -2048;
    push_model();
    feed(16);
    wait_drain();

    gaps_en = 1'b1;
    for (int b = 0; b < 128; b++) begin
      rand_block();
      push_model();
      feed(16);
    end
    wait_drain();

    rand_block();
    feed(7);
    while (fifo_q.size() != 0) @(negedge tb_clk);
    repeat (4) @(negedge tb_clk);
    #2 rst = 1'b0;
    #1;
    chk("midreset_valid", valid_out, 0);
    chk("midreset_re", data_re_out, 0);
    chk("midreset_im", data_im_out, 0);
    chk("midreset_rd", fifo_rd, 0);
    repeat (3) @(negedge tb_clk);
    rst = 1'b1;

    for (int b = 0; b < 128; b++) begin
      rand_block();
      push_model();
      feed(16);
    end
    wait_drain();
    repeat (10) @(negedge tb_clk);

    chk("rd_while_empty", rd_while_empty, 0);
    chk("bins_seen", bins_seen, 783);
    chk("exp_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
